// File: rtl/body_physics_stepper_pkg.sv
// Shared types and constants for the three-body physics stepper.
// Buses pack bodies as {C,B,A}, POS_W bits per body, A in the low bits.
package three_body_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAIR0,
        S_PAIR1,
        S_PAIR2,
        S_VEL,
        S_POS,
        S_COMMIT
    } state_t;

    localparam int unsigned NBODY = 3;
    localparam int unsigned POS_W = 10;
    localparam int unsigned VEL_W = 5;
    localparam int unsigned ACC_W = 4;
    localparam int unsigned FRC_W = 3;
    localparam int unsigned BUS_W = NBODY * POS_W;

    localparam logic [BUS_W-1:0] RST_POS_X = {10'd200, 10'd420, 10'd300};
    localparam logic [BUS_W-1:0] RST_POS_Y = {10'd20, 10'd300, 10'd150};

endpackage

// File: rtl/body_physics_stepper_pair_force.sv
// Combinational pairwise attraction: signed per-axis force on body i from body j.
// The force on body j is the negation; the caller applies both.
module pair_force
    import three_body_pkg::*;
#(
    parameter int unsigned NEAR = 40,
    parameter int unsigned FAR  = 200
) (
    input  logic [POS_W-1:0]        i_xi,
    input  logic [POS_W-1:0]        i_yi,
    input  logic [POS_W-1:0]        i_xj,
    input  logic [POS_W-1:0]        i_yj,
    output logic signed [FRC_W-1:0] o_fx,
    output logic signed [FRC_W-1:0] o_fy
);

    localparam logic [POS_W:0] NEAR_D = (POS_W + 1)'(NEAR);
    localparam logic [POS_W:0] FAR_D  = (POS_W + 1)'(FAR);

    logic signed [POS_W:0]   w_dx;
    logic signed [POS_W:0]   w_dy;
    logic [POS_W:0]          w_adx;
    logic [POS_W:0]          w_ady;
    logic [POS_W:0]          w_d;
    logic signed [FRC_W-1:0] w_f;

    assign w_dx  = $signed({1'b0, i_xj}) - $signed({1'b0, i_xi});
    assign w_dy  = $signed({1'b0, i_yj}) - $signed({1'b0, i_yi});
    assign w_adx = w_dx[POS_W] ? -w_dx : w_dx;
    assign w_ady = w_dy[POS_W] ? -w_dy : w_dy;
    assign w_d   = w_adx + w_ady;

    assign w_f = (w_d < NEAR_D) ? 3'sd2 : (w_d < FAR_D) ? 3'sd1 : 3'sd0;

    assign o_fx = (w_dx == '0) ? '0 : (w_dx[POS_W] ? -w_f : w_f);
    assign o_fy = (w_dy == '0) ? '0 : (w_dy[POS_W] ? -w_f : w_f);

endmodule

// File: rtl/body_physics_stepper.sv
// Per-frame three-body stepper: accumulate pair forces, update velocity, then
// position into shadow registers, committing all positions together.
module body_physics_stepper
    import three_body_pkg::*;
#(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned RADIUS = 20,
    parameter int unsigned NEAR   = 40,
    parameter int unsigned FAR    = 200,
    parameter int unsigned VMAX   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             hold,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic [BUS_W-1:0] seed_x,
    input  logic [BUS_W-1:0] seed_y,
    output logic [BUS_W-1:0] pos_x,
    output logic [BUS_W-1:0] pos_y,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam logic signed [POS_W:0] LO   = (POS_W + 1)'(RADIUS);
    localparam logic signed [POS_W:0] HI_X = (POS_W + 1)'(H_RES - 1 - RADIUS);
    localparam logic signed [POS_W:0] HI_Y = (POS_W + 1)'(V_RES - 1 - RADIUS);
    localparam logic signed [VEL_W:0] VLIM   = (VEL_W + 1)'(VMAX);
    localparam logic signed [VEL_W:0] VLIM_N = -VLIM;

    state_t r_state, w_next;

    logic [POS_W-1:0]        r_px [NBODY];
    logic [POS_W-1:0]        r_py [NBODY];
    logic [POS_W-1:0]        r_sx [NBODY];
    logic [POS_W-1:0]        r_sy [NBODY];
    logic signed [VEL_W-1:0] r_vx [NBODY];
    logic signed [VEL_W-1:0] r_vy [NBODY];
    logic signed [ACC_W-1:0] r_ax [NBODY];
    logic signed [ACC_W-1:0] r_ay [NBODY];
    logic                    r_done;
    logic                    r_overrun;

    logic [1:0]              w_i, w_j;
    logic signed [FRC_W-1:0] w_fx, w_fy;
    logic signed [VEL_W:0]   w_vsx [NBODY];
    logic signed [VEL_W:0]   w_vsy [NBODY];
    logic signed [VEL_W-1:0] w_nvx [NBODY];
    logic signed [VEL_W-1:0] w_nvy [NBODY];
    logic signed [POS_W:0]   w_tx  [NBODY];
    logic signed [POS_W:0]   w_ty  [NBODY];
    logic [POS_W-1:0]        w_npx [NBODY];
    logic [POS_W-1:0]        w_npy [NBODY];
    logic                    w_flx [NBODY];
    logic                    w_fly [NBODY];

    always_comb begin
        w_i = 2'd0;
        w_j = 2'd1;
        case (r_state)
            S_PAIR1: w_j = 2'd2;
            S_PAIR2: begin
                w_i = 2'd1;
                w_j = 2'd2;
            end
            default: ;
        endcase
    end

    pair_force #(.NEAR(NEAR), .FAR(FAR)) u_pair_force (
        .i_xi (r_px[w_i]),
        .i_yi (r_py[w_i]),
        .i_xj (r_px[w_j]),
        .i_yj (r_py[w_j]),
        .o_fx (w_fx),
        .o_fy (w_fy)
    );

    // Velocity saturation and wall reflection, evaluated for every body in parallel.
    always_comb begin
        for (int unsigned b = 0; b < NBODY; b++) begin
            w_vsx[b] = (VEL_W + 1)'(r_vx[b]) + (VEL_W + 1)'(r_ax[b]);
            w_vsy[b] = (VEL_W + 1)'(r_vy[b]) + (VEL_W + 1)'(r_ay[b]);
            w_nvx[b] = (w_vsx[b] > VLIM) ? VLIM[VEL_W-1:0] :
                       (w_vsx[b] < VLIM_N) ? VLIM_N[VEL_W-1:0] : w_vsx[b][VEL_W-1:0];
            w_nvy[b] = (w_vsy[b] > VLIM) ? VLIM[VEL_W-1:0] :
                       (w_vsy[b] < VLIM_N) ? VLIM_N[VEL_W-1:0] : w_vsy[b][VEL_W-1:0];

            w_tx[b]  = $signed({1'b0, r_px[b]}) + (POS_W + 1)'(r_vx[b]);
            w_ty[b]  = $signed({1'b0, r_py[b]}) + (POS_W + 1)'(r_vy[b]);
            w_flx[b] = 1'b1;
            w_fly[b] = 1'b1;
            if (w_tx[b] < LO)        w_npx[b] = LO[POS_W-1:0];
            else if (w_tx[b] > HI_X) w_npx[b] = HI_X[POS_W-1:0];
            else begin
                w_npx[b] = w_tx[b][POS_W-1:0];
                w_flx[b] = 1'b0;
            end
            if (w_ty[b] < LO)        w_npy[b] = LO[POS_W-1:0];
            else if (w_ty[b] > HI_Y) w_npy[b] = HI_Y[POS_W-1:0];
            else begin
                w_npy[b] = w_ty[b][POS_W-1:0];
                w_fly[b] = 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!seed_valid && frame_tick && !hold) w_next = S_PAIR0;
            S_PAIR0:  w_next = S_PAIR1;
            S_PAIR1:  w_next = S_PAIR2;
            S_PAIR2:  w_next = S_VEL;
            S_VEL:    w_next = S_POS;
            S_POS:    w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            for (int unsigned b = 0; b < NBODY; b++) begin
                r_px[b] <= RST_POS_X[b*POS_W +: POS_W];
                r_py[b] <= RST_POS_Y[b*POS_W +: POS_W];
                r_sx[b] <= RST_POS_X[b*POS_W +: POS_W];
                r_sy[b] <= RST_POS_Y[b*POS_W +: POS_W];
                r_vx[b] <= '0;
                r_vy[b] <= '0;
                r_ax[b] <= '0;
                r_ay[b] <= '0;
            end
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_COMMIT);
            if (frame_tick && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    for (int unsigned b = 0; b < NBODY; b++) begin
                        if (seed_valid) begin
                            r_px[b] <= seed_x[b*POS_W +: POS_W];
                            r_py[b] <= seed_y[b*POS_W +: POS_W];
                            r_sx[b] <= seed_x[b*POS_W +: POS_W];
                            r_sy[b] <= seed_y[b*POS_W +: POS_W];
                            r_vx[b] <= '0;
                            r_vy[b] <= '0;
                        end else if (frame_tick && !hold) begin
                            r_ax[b] <= '0;
                            r_ay[b] <= '0;
                        end
                    end
                end
                S_PAIR0, S_PAIR1, S_PAIR2: begin
                    r_ax[w_i] <= r_ax[w_i] + ACC_W'(w_fx);
                    r_ay[w_i] <= r_ay[w_i] + ACC_W'(w_fy);
                    r_ax[w_j] <= r_ax[w_j] - ACC_W'(w_fx);
                    r_ay[w_j] <= r_ay[w_j] - ACC_W'(w_fy);
                end
                S_VEL: begin
                    for (int unsigned b = 0; b < NBODY; b++) begin
                        r_vx[b] <= w_nvx[b];
                        r_vy[b] <= w_nvy[b];
                    end
                end
                S_POS: begin
                    for (int unsigned b = 0; b < NBODY; b++) begin
                        r_sx[b] <= w_npx[b];
                        r_sy[b] <= w_npy[b];
                        if (w_flx[b]) r_vx[b] <= -r_vx[b];
                        if (w_fly[b]) r_vy[b] <= -r_vy[b];
                    end
                end
                S_COMMIT: begin
                    for (int unsigned b = 0; b < NBODY; b++) begin
                        r_px[b] <= r_sx[b];
                        r_py[b] <= r_sy[b];
                    end
                end
                default: ;
            endcase
        end
    end

    assign pos_x      = {r_px[2], r_px[1], r_px[0]};
    assign pos_y      = {r_py[2], r_py[1], r_py[0]};
    assign seed_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_body_physics_stepper.sv
// Bench for body_physics_stepper: three parameterisations share one stimulus stream
// and are checked against table constants and an integer physics model.
module tb_body_physics_stepper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        hold = 1'b0;
    logic        seed_valid = 1'b0;
    logic [29:0] seed_x = '0;
    logic [29:0] seed_y = '0;
    logic [29:0] px [3];
    logic [29:0] py [3];
    logic        rdy [3];
    logic        bsy [3];
    logic        dn  [3];
    logic        ovr [3];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    body_physics_stepper dut0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hold(hold),
        .seed_valid(seed_valid), .seed_ready(rdy[0]), .seed_x(seed_x), .seed_y(seed_y),
        .pos_x(px[0]), .pos_y(py[0]), .busy(bsy[0]), .done(dn[0]), .overrun(ovr[0])
    );
    body_physics_stepper #(.FAR(240)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hold(hold),
        .seed_valid(seed_valid), .seed_ready(rdy[1]), .seed_x(seed_x), .seed_y(seed_y),
        .pos_x(px[1]), .pos_y(py[1]), .busy(bsy[1]), .done(dn[1]), .overrun(ovr[1])
    );
    body_physics_stepper #(.VMAX(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .hold(hold),
        .seed_valid(seed_valid), .seed_ready(rdy[2]), .seed_x(seed_x), .seed_y(seed_y),
        .pos_x(px[2]), .pos_y(py[2]), .busy(bsy[2]), .done(dn[2]), .overrun(ovr[2])
    );

    // Behavioural model state, [instance][body]
    int mx [3][3];
    int my [3][3];
    int mvx[3][3];
    int mvy[3][3];
    int p_far [3] = '{200, 240, 200};
    int p_vmax[3] = '{8, 8, 3};
    logic [29:0] mid_px [3];

    typedef struct {
        int          inst;
        logic [29:0] sx;
        logic [29:0] sy;
        int          ticks;
        logic [29:0] ex;
        logic [29:0] ey;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [29:0] pack(int a, int b, int c);
        return {10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic int sgn(int v);
        return (v > 0) ? 1 : (v < 0) ? -1 : 0;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_step(int n);
        int ax[3];
        int ay[3];
        int f, dx, dy, nx, ny;
        for (int b = 0; b < 3; b++) begin ax[b] = 0; ay[b] = 0; end
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 3; j++) begin
                dx = mx[n][j] - mx[n][i];
                dy = my[n][j] - my[n][i];
                f = (iabs(dx) + iabs(dy) < 40) ? 2 : (iabs(dx) + iabs(dy) < p_far[n]) ? 1 : 0;
                ax[i] += sgn(dx) * f; ax[j] -= sgn(dx) * f;
                ay[i] += sgn(dy) * f; ay[j] -= sgn(dy) * f;
            end
        end
        for (int b = 0; b < 3; b++) begin
            mvx[n][b] = mvx[n][b] + ax[b];
            mvy[n][b] = mvy[n][b] + ay[b];
            if (mvx[n][b] > p_vmax[n]) mvx[n][b] = p_vmax[n];
            if (mvx[n][b] < -p_vmax[n]) mvx[n][b] = -p_vmax[n];
            if (mvy[n][b] > p_vmax[n]) mvy[n][b] = p_vmax[n];
            if (mvy[n][b] < -p_vmax[n]) mvy[n][b] = -p_vmax[n];
            nx = mx[n][b] + mvx[n][b];
            ny = my[n][b] + mvy[n][b];
            if (nx < 20) begin nx = 20; mvx[n][b] = -mvx[n][b]; end
            else if (nx > 619) begin nx = 619; mvx[n][b] = -mvx[n][b]; end
            if (ny < 20) begin ny = 20; mvy[n][b] = -mvy[n][b]; end
            else if (ny > 459) begin ny = 459; mvy[n][b] = -mvy[n][b]; end
            mx[n][b] = nx;
            my[n][b] = ny;
        end
    endfunction

    task automatic check(input string nm, input logic [29:0] act, input logic [29:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            mx[n][0] = 300; my[n][0] = 150;
            mx[n][1] = 420; my[n][1] = 300;
            mx[n][2] = 200; my[n][2] = 20;
            for (int b = 0; b < 3; b++) begin mvx[n][b] = 0; mvy[n][b] = 0; end
        end
    endtask

    task automatic do_seed(input logic [29:0] sx, input logic [29:0] sy);
        @(negedge clk);
        seed_x = sx; seed_y = sy; seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            for (int b = 0; b < 3; b++) begin
                mx[n][b] = int'(sx[b*10 +: 10]);
                my[n][b] = int'(sy[b*10 +: 10]);
                mvx[n][b] = 0; mvy[n][b] = 0;
            end
        end
    endtask

    // One frame_tick; samples dut0 busy/done for a fixed window after E0.
    task automatic do_tick(output int lat, output int bc, output int dc);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        bc = int'(bsy[0]); dc = 0; lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 5) for (int n = 0; n < 3; n++) mid_px[n] = px[n];
            bc += int'(bsy[0]);
            if (dn[0]) begin
                dc++;
                if (lat == 0) lat = k;
            end
        end
        for (int n = 0; n < 3; n++) model_step(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, dc;
        logic [29:0] rx, ry;

        tbl[0] = '{inst: 0, sx: pack(300, 420, 200), sy: pack(150, 300, 20), ticks: 1,
                   ex: pack(300, 420, 200), ey: pack(150, 300, 20)};
        tbl[1] = '{inst: 1, sx: pack(300, 420, 200), sy: pack(150, 300, 20), ticks: 1,
                   ex: pack(299, 420, 201), ey: pack(149, 300, 21)};
        tbl[2] = '{inst: 0, sx: pack(618, 619, 20), sy: pack(240, 240, 20), ticks: 1,
                   ex: pack(619, 617, 20), ey: pack(240, 240, 20)};
        tbl[3] = '{inst: 0, sx: pack(618, 619, 20), sy: pack(240, 240, 20), ticks: 2,
                   ex: pack(615, 617, 20), ey: pack(240, 240, 20)};
        tbl[4] = '{inst: 2, sx: pack(300, 310, 20), sy: pack(240, 240, 20), ticks: 2,
                   ex: pack(305, 305, 20), ey: pack(240, 240, 20)};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset_pos_x", px[0], pack(300, 420, 200));
        check("reset_pos_y", py[0], pack(150, 300, 20));
        check("reset_busy", {29'b0, bsy[0]}, 30'd0);
        check("reset_done", {29'b0, dn[0]}, 30'd0);
        check("reset_overrun", {29'b0, ovr[0]}, 30'd0);
        check("reset_ready", {29'b0, rdy[0]}, 30'd1);

        // Defaults: all pairs at or beyond FAR, nothing moves
        do_tick(lat, bc, dc);
        check("latency", 30'(lat), 30'd6);
        check("busy_cycles", 30'(bc), 30'd6);
        check("done_pulses", 30'(dc), 30'd1);
        check("default_pos_x", px[0], pack(300, 420, 200));
        check("far240_mid_x", mid_px[1], pack(300, 420, 200));
        check("far240_pos_x", px[1], pack(299, 420, 201));

        // Hold suppresses the tick without flagging overrun
        hold = 1'b1;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        bc = 0; dc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bc += int'(bsy[0]); dc += int'(dn[0]);
        end
        hold = 1'b0;
        check("hold_busy", 30'(bc), 30'd0);
        check("hold_done", 30'(dc), 30'd0);
        check("hold_overrun", {29'b0, ovr[0]}, 30'd0);

        // Seed and tick on the same edge: seed wins
        @(negedge clk);
        seed_x = pack(100, 500, 50); seed_y = pack(100, 200, 300);
        seed_valid = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0; frame_tick = 1'b0;
        check("seedtick_pos_x", px[0], pack(100, 500, 50));
        check("seedtick_pos_y", py[0], pack(100, 200, 300));
        check("seedtick_busy", {29'b0, bsy[0]}, 30'd0);
        dc = 0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); dc += int'(dn[0]); end
        check("seedtick_done", 30'(dc), 30'd0);
        check("seedtick_overrun", {29'b0, ovr[0]}, 30'd0);
        for (int n = 0; n < 3; n++)
            for (int b = 0; b < 3; b++) begin
                mx[n][b] = (b == 0) ? 100 : (b == 1) ? 500 : 50;
                my[n][b] = (b == 0) ? 100 : (b == 1) ? 200 : 300;
                mvx[n][b] = 0; mvy[n][b] = 0;
            end

        // Directed table
        foreach (tbl[t]) begin
            do_seed(tbl[t].sx, tbl[t].sy);
            for (int s = 0; s < tbl[t].ticks; s++) begin
                do_tick(lat, bc, dc);
                if (s == 0) check($sformatf("tbl%0d_mid_x", t), mid_px[tbl[t].inst], tbl[t].sx);
            end
            check($sformatf("tbl%0d_pos_x", t), px[tbl[t].inst], tbl[t].ex);
            check($sformatf("tbl%0d_pos_y", t), py[tbl[t].inst], tbl[t].ey);
        end

        // Randomised clustered seeds against the model
        for (int it = 0; it < 20; it++) begin
            int bx, by;
            bx = int'($urandom_range(0, 700));
            by = int'($urandom_range(0, 500));
            rx = pack(bx + int'($urandom_range(0, 300)), bx + int'($urandom_range(0, 300)),
                      bx + int'($urandom_range(0, 300)));
            ry = pack(by + int'($urandom_range(0, 300)), by + int'($urandom_range(0, 300)),
                      by + int'($urandom_range(0, 300)));
            do_seed(rx, ry);
            for (int s = 0; s < 3; s++) begin
                do_tick(lat, bc, dc);
                for (int n = 0; n < 3; n++) begin
                    check($sformatf("rand%0d_i%0d_x", it, n), px[n], pack(mx[n][0], mx[n][1], mx[n][2]));
                    check($sformatf("rand%0d_i%0d_y", it, n), py[n], pack(my[n][0], my[n][1], my[n][2]));
                end
            end
        end

        // Second tick mid-step: ignored, overrun set, single done
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        bc = int'(bsy[0]); dc = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) frame_tick = 1'b1;
            if (k == 3) frame_tick = 1'b0;
            bc += int'(bsy[0]); dc += int'(dn[0]);
        end
        for (int n = 0; n < 3; n++) model_step(n);
        check("ovr_flag", {29'b0, ovr[0]}, 30'd1);
        check("ovr_busy_cycles", 30'(bc), 30'd6);
        check("ovr_done_pulses", 30'(dc), 30'd1);
        check("ovr_pos_x", px[0], pack(mx[0][0], mx[0][1], mx[0][2]));

        // Asynchronous reset in the middle of a step
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {29'b0, bsy[0]}, 30'd0);
        check("abort_overrun", {29'b0, ovr[0]}, 30'd0);
        check("abort_pos_x", px[0], pack(300, 420, 200));
        check("abort_pos_y", py[0], pack(150, 300, 20));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_tick(lat, bc, dc);
        check("post_abort_far240_y", py[1], pack(149, 300, 21));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
